gcd_operand_queue: RTL
======================

// Module: gcd_operand_queue
//
// PURPOSE
//  Elastic buffer for operand pairs (A,B), placed directly upstream of the GCD unit's operand port.
//  Decouples the request producer from the GCD iteration latency: absorbs bursts of up to DEPTH pairs.
//  Presents them in order on a val/rdy port that connects straight to the GCD unit's operand inputs.
//  Exposes its current occupancy for performance counters and debug.
//
// PARAMETERS
//  W      16  operand bit width; must match the GCD unit's W
//  DEPTH  4   number of (A,B) entries; power of two, >= 2
//
// PORTS
//  clk          in   1               clock, all state rising-edge
//  reset        in   1               asynchronous, active-high reset
//  enq_bits_A   in   W               operand A from producer
//  enq_bits_B   in   W               operand B from producer
//  enq_val      in   1               producer has a valid pair
//  enq_rdy      out  1               queue can accept a pair this cycle
//  deq_bits_A   out  W               head operand A, to GCD operands_bits_A
//  deq_bits_B   out  W               head operand B, to GCD operands_bits_B
//  deq_val      out  1               head entry valid, to GCD operands_val
//  deq_rdy      in   1               consumer accepts head, from GCD operands_rdy
//  count        out  $clog2(DEPTH)+1 number of occupied entries, 0..DEPTH
//
// BEHAVIOUR
//  - Reset (async, active-high): count=0, wr_ptr=rd_ptr=0, deq_val=0, enq_rdy=1. Storage is not reset.
//    Reset asserted mid-transfer discards all entries immediately.
//  - enq_fire = enq_val & enq_rdy; deq_fire = deq_val & deq_rdy. A transfer happens only on the clock edge where its fire is high.
//  - enq_rdy = (count != DEPTH): it is a function of state only. There is no combinational path from deq_rdy to enq_rdy.
//  - deq_val = (count != 0): it is a function of state only. There is no combinational path from enq_val to deq_val.
//  - deq_bits_A/B = storage[rd_ptr]. They are undefined when deq_val=0; the bench must not check them then.
//  - Latency: a pair enqueued at edge N is visible on deq_* after edge N, even when empty (no bypass).
//    Minimum enq-to-deq latency is 1 cycle.
//  - Throughput: one enq and one deq per cycle are sustained when 0 < count < DEPTH.
//  - Update at each edge:
//      enq_fire only: storage[wr_ptr]<=enq bits; wr_ptr++; count++
//      deq_fire only: rd_ptr++; count--
//      both         : write + both pointers advance; count unchanged (legal only when 0<count<DEPTH)
//  - Empty: deq_fire is impossible; a lone enq is accepted.
//  - Full: enq_fire is impossible, even if deq_rdy=1 in the same cycle. The producer sees enq_rdy=1 one cycle after a dequeue.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally; count never wraps.
//  - Order is strictly FIFO; A and B of a pair are always stored and emitted together.
//  - enq_bits are ignored when enq_val=0. Holding enq_val with changing bits while enq_rdy=0 is a producer protocol error.
//    The queue samples whatever is present on the accepting edge.
//
// STRUCTURE
//  - Shared package/header gcd_pkg holds:
//      GCD_W (default operand width, 16)
//      GCD_QDEPTH (default queue depth, 4)
//      a localparam helper for the count width
//  - One sub-module, gcd_queue_ctrl(DEPTH): wr_ptr, rd_ptr, count, enq_rdy, deq_val, and the write-enable/index outputs.
//  - Top level: the ctrl instance plus a DEPTH x 2W register array with a read mux indexed by rd_ptr.
//
// TESTING
//  1. Reset, then idle: count=0, deq_val=0, enq_rdy=1. Assert reset mid-run with count=3 -> count=0 and deq_val=0 without waiting for a clock.
//  2. Enqueue (48,18) at edge N with deq_rdy=0 -> deq_val=1 and deq_bits=(48,18) after edge N. Then deq_rdy=1 -> count=0 after the next edge.
//  3. Fill: 4 pairs (1,1),(2,2),(3,3),(4,4) with deq_rdy=0 -> count=4, enq_rdy=0.
//     A 5th pair offered with deq_rdy=1 is not taken that cycle. Dequeue order is 1,2,3,4.
//  4. Streaming: enq_val=1 and deq_rdy=1 every cycle for 20 pairs (i,2i) starting from count=1 -> count stays 1 and outputs emerge in order.
//  5. Wrap: 10 push/pop rounds of 3 pairs each -> pointers wrap and data stays in order. Check with a scoreboard.
//  6. Connected to the GCD unit, issue random operand pairs (e.g. (27,15)->3, (0,5)->5) with random result_rdy backpressure.
//     Expect results in order with no loss or duplication.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants for the GCD datapath and its operand queue.
package gcd_pkg;

  localparam int unsigned GCD_W      = 16;
  localparam int unsigned GCD_QDEPTH = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned gcd_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned GCD_CNT_W = gcd_cnt_w(GCD_QDEPTH);

endpackage

// File: rtl/gcd_queue_ctrl.sv
// Pointer and occupancy control for the GCD operand queue.
module gcd_queue_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned DEPTH = GCD_QDEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_val,
  input  logic                       deq_rdy,
  output logic                       enq_rdy,
  output logic                       deq_val,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = gcd_cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq_fire, deq_fire;

  // Handshake outputs depend on registered occupancy only.
  assign enq_rdy  = (count_q != CW'(DEPTH));
  assign deq_val  = (count_q != '0);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_rdy & deq_val;

  assign wr_en  = enq_fire;
  assign wr_idx = wr_ptr_q;
  assign rd_idx = rd_ptr_q;
  assign count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gcd_operand_queue.sv
// Elastic FIFO of (A,B) operand pairs feeding the GCD unit's operand port.
module gcd_operand_queue
  import gcd_pkg::*;
#(
  parameter int unsigned W     = GCD_W,
  parameter int unsigned DEPTH = GCD_QDEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           enq_bits_A,
  input  logic [W-1:0]           enq_bits_B,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  output logic [W-1:0]           deq_bits_A,
  output logic [W-1:0]           deq_bits_B,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic          wr_en;
  logic [PW-1:0] wr_idx, rd_idx;

  // A and B share one entry so a pair can never be split.
  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] mem_d [DEPTH];

  gcd_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .deq_rdy (deq_rdy),
    .enq_rdy (enq_rdy),
    .deq_val (deq_val),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .rd_idx  (rd_idx),
    .count   (count)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = {enq_bits_A, enq_bits_B};
  end

  // Storage is intentionally left unreset; validity comes from the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {deq_bits_A, deq_bits_B} = mem_q[rd_idx];

endmodule
